// File: rtl/sound_pkg.sv
// Shared constants for the sound channel register front-ends.
// Register offsets, read-back masks, frame-sequencer steps, default divider.
package sound_pkg;

  localparam logic [1:0] NR_X1 = 2'd0;
  localparam logic [1:0] NR_X2 = 2'd1;
  localparam logic [1:0] NR_X3 = 2'd2;
  localparam logic [1:0] NR_X4 = 2'd3;

  localparam logic [7:0] RD_MASK_X1 = 8'hFF;
  localparam logic [7:0] RD_MASK_X2 = 8'h00;
  localparam logic [7:0] RD_MASK_X3 = 8'h00;
  localparam logic [7:0] RD_MASK_X4 = 8'hBF;

  localparam logic [2:0] ENV_STEP = 3'd7;

  localparam int unsigned FS_DIV_DEFAULT = 8192;

  // length clock runs on the even steps 0,2,4,6
  function automatic logic is_len_step(input logic [2:0] s);
    return ~s[0];
  endfunction

endpackage

// File: rtl/sound_frame_seq.sv
// Frame sequencer: 512 Hz divider, 3-bit step, length/envelope pulses.
// Ports: clk, rst (async low), enable, clk_length_ctr, clk_vol_env.
module sound_frame_seq
  import sound_pkg::*;
#(
  parameter int unsigned FS_DIV = FS_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic clk_length_ctr,
  output logic clk_vol_env
);

  localparam int DW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FS_DIV - 1);

  logic [DW-1:0] div;
  logic [2:0]    step;
  logic          wrap;
  logic [2:0]    step_nxt;

  assign wrap     = (div == DIV_LAST);
  assign step_nxt = step + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div            <= '0;
      step           <= '0;
      clk_length_ctr <= 1'b0;
      clk_vol_env    <= 1'b0;
    end else if (!enable) begin
      div            <= '0;
      step           <= '0;
      clk_length_ctr <= 1'b0;
      clk_vol_env    <= 1'b0;
    end else begin
      div            <= wrap ? '0 : div + 1'b1;
      if (wrap) step <= step_nxt;
      clk_length_ctr <= wrap && is_len_step(step_nxt);
      clk_vol_env    <= wrap && (step_nxt == ENV_STEP);
    end
  end

endmodule

// File: rtl/sound_noise_ctrl.sv
// Noise channel register front-end (NR41-NR44), trigger pulse, frame clocks.
// Ports: bus (cs/wr/rd/a/din/dout), NR fields, start, clk_length_ctr,
// clk_vol_env; dac_en only when SOUND_NOISE_DAC_GATE_EN is defined.
module sound_noise_ctrl
  import sound_pkg::*;
#(
  parameter int unsigned FS_DIV       = FS_DIV_DEFAULT,
  parameter int unsigned START_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sound_enable,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic [1:0] a,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [5:0] length,
  output logic [3:0] initial_volume,
  output logic       envelope_increasing,
  output logic [2:0] num_envelope_sweeps,
  output logic [3:0] shift_clock_freq,
  output logic       counter_width,
  output logic [2:0] freq_dividing_ratio,
  output logic       single,
  output logic       start,
`ifdef SOUND_NOISE_DAC_GATE_EN
  output logic       dac_en,
`endif
  output logic       clk_length_ctr,
  output logic       clk_vol_env
);

  logic       wr_en;
  logic       trig;
  logic       abort;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [7:0] nr42;
  logic [7:0] nr43;
  logic [7:0] rd_val;

  assign wr_en = cs & wr & sound_enable;
  assign nr42  = {initial_volume, envelope_increasing, num_envelope_sweeps};
  assign nr43  = {shift_clock_freq, counter_width, freq_dividing_ratio};

`ifdef SOUND_NOISE_DAC_GATE_EN
  assign trig  = wr_en && (a == NR_X4) && din[7] && dac_en;
  assign abort = wr_en && (a == NR_X2) && (din[7:3] == 5'd0);
`else
  assign trig  = wr_en && (a == NR_X4) && din[7];
  assign abort = 1'b0;
`endif

  always_comb begin
    rd_val = 8'hFF;
    unique case (1'b1)
      (a == NR_X1): rd_val = RD_MASK_X1;
      (a == NR_X2): rd_val = RD_MASK_X2 | nr42;
      (a == NR_X3): rd_val = RD_MASK_X3 | nr43;
      (a == NR_X4): rd_val = RD_MASK_X4 | {1'b0, single, 6'd0};
      default:      rd_val = 8'hFF;
    endcase
  end

  // retrigger simply reloads, stretching an in-flight pulse
  always_comb begin
    cnt_nxt = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
    if (trig) cnt_nxt = 4'(START_CYCLES);
    if (!sound_enable || abort) cnt_nxt = 4'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 4'd0;
      start <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      start <= (cnt_nxt != 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      length              <= '0;
      initial_volume      <= '0;
      envelope_increasing <= 1'b0;
      num_envelope_sweeps <= '0;
      shift_clock_freq    <= '0;
      counter_width       <= 1'b0;
      freq_dividing_ratio <= '0;
      single              <= 1'b0;
    end else if (!sound_enable) begin
      length              <= '0;
      initial_volume      <= '0;
      envelope_increasing <= 1'b0;
      num_envelope_sweeps <= '0;
      shift_clock_freq    <= '0;
      counter_width       <= 1'b0;
      freq_dividing_ratio <= '0;
      single              <= 1'b0;
    end else if (cs && wr) begin
      unique case (1'b1)
        (a == NR_X1): length <= din[5:0];
        (a == NR_X2): begin
          initial_volume      <= din[7:4];
          envelope_increasing <= din[3];
          num_envelope_sweeps <= din[2:0];
        end
        (a == NR_X3): begin
          shift_clock_freq    <= din[7:4];
          counter_width       <= din[3];
          freq_dividing_ratio <= din[2:0];
        end
        (a == NR_X4): single <= din[6];
        default: ;
      endcase
    end
  end

`ifdef SOUND_NOISE_DAC_GATE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dac_en <= 1'b0;
    else if (!sound_enable)
      dac_en <= 1'b0;
    else if (wr_en && (a == NR_X2))
      dac_en <= |din[7:3];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dout <= 8'hFF;
    else if (cs && rd)
      dout <= rd_val;
  end

  sound_frame_seq #(
    .FS_DIV (FS_DIV)
  ) u_seq (
    .clk            (clk),
    .rst            (rst),
    .enable         (sound_enable),
    .clk_length_ctr (clk_length_ctr),
    .clk_vol_env    (clk_vol_env)
  );

endmodule
